// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transfer arbiter.
package spi_arb_pkg;

    localparam int unsigned SPI_BYTE_W     = 8;
    localparam int unsigned TO_CYC_DEFAULT = 1024;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitLo,
        StWaitHi,
        StNext
    } state_t;

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module spi_rr_picker #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [NREQ-1:0]  oh_o,
    output logic [PTR_W-1:0] idx_o
);

    int unsigned k;

    // Scan from the pointer upwards so the last owner is checked last
    always_comb begin
        valid_o = 1'b0;
        oh_o    = '0;
        idx_o   = '0;
        k       = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            k = (32'(ptr_i) + off) % NREQ;
            if (!valid_o && req_i[k]) begin
                valid_o = 1'b1;
                oh_o[k] = 1'b1;
                idx_o   = PTR_W'(k);
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SpiMaster byte engine between NREQ requesters, sequencing multi-byte bursts.
// Optional per-byte timeout is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_xfer_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned TO_CYC = TO_CYC_DEFAULT
) (
    input  logic                         CLK,
    input  logic                         RST_n,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*LEN_W-1:0]        req_len,
    input  logic [NREQ*SPI_BYTE_W-1:0]   tx_data,
    output logic [NREQ-1:0]              gnt,
    output logic [NREQ-1:0]              tx_pop,
    output logic [SPI_BYTE_W-1:0]        rx_data,
    output logic [NREQ-1:0]              rx_valid,
    output logic [NREQ-1:0]              done,
    output logic                         err,
    output logic                         spi_ctl,
    output logic [SPI_BYTE_W-1:0]        spi_txd,
    input  logic [SPI_BYTE_W-1:0]        spi_rxd,
    input  logic                         spi_csn
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      sel_q, sel_d;
    logic [PTR_W-1:0]      rr_q, rr_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic [NREQ-1:0]       rx_valid_q, rx_valid_d;
    logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  spi_ctl_q, spi_ctl_d;
    logic [SPI_BYTE_W-1:0] spi_txd_q, spi_txd_d;

    logic                  pick_valid;
    logic [NREQ-1:0]       pick_oh;
    logic [PTR_W-1:0]      pick_idx;
    logic [LEN_W-1:0]      pick_len;
    logic [NREQ-1:0]       sel_oh;
    logic [PTR_W-1:0]      rr_next;
    logic                  timeout;

    spi_rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (rr_q),
        .valid_o (pick_valid),
        .oh_o    (pick_oh),
        .idx_o   (pick_idx)
    );

    assign pick_len = req_len[32'(pick_idx)*LEN_W +: LEN_W];
    assign sel_oh   = NREQ'(1) << sel_q;
    // Owner just served drops to lowest priority next time
    assign rr_next  = (32'(sel_q) == NREQ - 1) ? '0 : sel_q + 1'b1;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Per-byte watchdog: cleared when a byte is launched, counts while waiting on the engine
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == StStart) begin
            to_cnt_d = '0;
        end else if (state_q == StWaitLo || state_q == StWaitHi) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Watchdog register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout = (state_q == StWaitLo || state_q == StWaitHi) &&
                     (to_cnt_q == TO_W'(TO_CYC - 1));
`else
    logic unused_to_cyc;
    assign unused_to_cyc = (TO_CYC == 0);
    assign timeout       = 1'b0;
`endif

    // State and datapath registers; spi_ctl and gnt drop asynchronously on reset
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            rx_valid_q <= '0;
            rx_data_q  <= '0;
            spi_ctl_q  <= 1'b0;
            spi_txd_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            spi_ctl_q  <= spi_ctl_d;
            spi_txd_q  <= spi_txd_d;
        end
    end

    // Next-state and datapath updates for the burst sequencer
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        rx_valid_d = '0;
        rx_data_d  = rx_data_q;
        spi_ctl_d  = spi_ctl_q;
        spi_txd_d  = spi_txd_q;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    cnt_d   = pick_len;
                    gnt_d   = pick_oh;
                    // Zero-length burst skips the engine and just reports done
                    state_d = (pick_len == '0) ? StNext : StStart;
                end
            end
            StStart: begin
                spi_txd_d = tx_data[32'(sel_q)*SPI_BYTE_W +: SPI_BYTE_W];
                spi_ctl_d = 1'b1;
                state_d   = StWaitLo;
            end
            StWaitLo: begin
                // Engine already busy also lands here; ctl stays high so no extra edge
                if (!spi_csn) begin
                    spi_ctl_d = 1'b0;
                    state_d   = StWaitHi;
                end
            end
            StWaitHi: begin
                if (spi_csn) begin
                    rx_data_d  = spi_rxd;
                    rx_valid_d = sel_oh;
                    cnt_d      = cnt_q - 1'b1;
                    state_d    = StNext;
                end
            end
            StNext: begin
                if (cnt_q != '0) begin
                    state_d = StStart;
                end else begin
                    gnt_d   = '0;
                    rr_d    = rr_next;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (timeout) begin
            spi_ctl_d = 1'b0;
            gnt_d     = '0;
            rr_d      = rr_next;
            state_d   = StIdle;
        end
    end

    // Owner-directed pulses decoded from the current state
    always_comb begin
        tx_pop = '0;
        done   = '0;
        err    = timeout;
        if (state_q == StStart) begin
            tx_pop = sel_oh;
        end
        if ((state_q == StNext && cnt_q == '0) || timeout) begin
            done = sel_oh;
        end
    end

    assign gnt      = gnt_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign spi_ctl  = spi_ctl_q;
    assign spi_txd  = spi_txd_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter with a simple SpiMaster engine model.
module tb_spi_xfer_arbiter;

    localparam int NREQ   = 2;
    localparam int LEN_W  = 4;
    localparam int TO_CYC = 16;

    logic                    CLK = 1'b0;
    logic                    RST_n;
    logic [NREQ-1:0]         req;
    logic [NREQ*LEN_W-1:0]   req_len;
    logic [NREQ*8-1:0]       tx_data;
    logic [NREQ-1:0]         gnt, tx_pop, rx_valid, done;
    logic [7:0]              rx_data, spi_txd, spi_rxd;
    logic                    err, spi_ctl, spi_csn;

    always #5 CLK = ~CLK;

    spi_xfer_arbiter #(
        .NREQ   (NREQ),
        .LEN_W  (LEN_W),
        .TO_CYC (TO_CYC)
    ) dut (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .req      (req),
        .req_len  (req_len),
        .tx_data  (tx_data),
        .gnt      (gnt),
        .tx_pop   (tx_pop),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .done     (done),
        .err      (err),
        .spi_ctl  (spi_ctl),
        .spi_txd  (spi_txd),
        .spi_rxd  (spi_rxd),
        .spi_csn  (spi_csn)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: expected pushed with stimulus, observed pushed by monitors
    logic [7:0] exp_txq[$], got_txq[$];
    logic [9:0] exp_rxq[$], got_rxq[$];
    logic [1:0] exp_doneq[$], got_doneq[$];
    logic [1:0] exp_gntq[$], got_gntq[$];

    // SpiMaster model: csn low one cycle after ctl, byte lasts 4 cycles
    logic       hold_high = 1'b0;
    logic [7:0] miso_val  = 8'h00;
    int         busy;

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            spi_csn <= 1'b1;
            spi_rxd <= 8'h00;
            busy    <= 0;
        end else if (spi_csn && spi_ctl && !hold_high) begin
            spi_csn <= 1'b0;
            busy    <= 3;
            got_txq.push_back(spi_txd);
        end else if (!spi_csn) begin
            if (busy == 0) begin
                spi_csn <= 1'b1;
                spi_rxd <= miso_val;
            end else begin
                busy <= busy - 1;
            end
        end
    end

    // Requester byte sources, advanced by tx_pop
    logic [7:0] src [NREQ][16];
    int         sidx [NREQ];
    logic       src_clr = 1'b0;

    always @(posedge CLK) begin
        for (int i = 0; i < NREQ; i++) begin
            if (src_clr) sidx[i] <= 0;
            else if (tx_pop[i]) sidx[i] <= sidx[i] + 1;
        end
    end

    always_comb begin
        tx_data = '0;
        for (int i = 0; i < NREQ; i++) tx_data[i*8 +: 8] = src[i][sidx[i] % 16];
    end

    // Output monitors sampled on the falling edge
    logic [1:0] gnt_prev = 2'b00;
    int gnt_cycles = 0, ctl_cycles = 0, pop_cnt = 0;

    always @(negedge CLK) begin
        if (rx_valid != 0) got_rxq.push_back({rx_valid, rx_data});
        if (done != 0) got_doneq.push_back(done);
        if (gnt != 0 && gnt_prev == 0) got_gntq.push_back(gnt);
        gnt_prev <= gnt;
        if (gnt != 0) gnt_cycles <= gnt_cycles + 1;
        if (spi_ctl) ctl_cycles <= ctl_cycles + 1;
        if (tx_pop != 0) pop_cnt <= pop_cnt + 1;
    end

    task automatic clear_sb();
        exp_txq.delete(); got_txq.delete();
        exp_rxq.delete(); got_rxq.delete();
        exp_doneq.delete(); got_doneq.delete();
        exp_gntq.delete(); got_gntq.delete();
    endtask

    task automatic load_src(input int r, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        src[r][0] = b0; src[r][1] = b1; src[r][2] = b2; src[r][3] = b3;
        src_clr = 1'b1;
        @(negedge CLK);
        src_clr = 1'b0;
    endtask

    task automatic test_reset();
        RST_n = 1'b0; req = '0; req_len = '0;
        repeat (3) @(negedge CLK);
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        checks++; if ({tx_pop, rx_valid, done} !== 6'b0) begin errors++;
            $display("FAIL reset_pulses: got %b expected 000000", {tx_pop, rx_valid, done}); end
        checks++; if ({err, spi_ctl} !== 2'b00) begin errors++;
            $display("FAIL reset_err_ctl: got %b expected 00", {err, spi_ctl}); end
        checks++; if ({spi_txd, rx_data} !== 16'h0000) begin errors++;
            $display("FAIL reset_data: got %h expected 0000", {spi_txd, rx_data}); end
        RST_n = 1'b1;
        repeat (4) @(negedge CLK);
        checks++; if (gnt !== 2'b00 || spi_ctl !== 1'b0) begin errors++;
            $display("FAIL idle_no_req: got gnt=%b ctl=%b expected 00/0", gnt, spi_ctl); end
    endtask

    task automatic test_single_burst();
        int p0;
        clear_sb();
        load_src(0, 8'hAB, 8'hCD, 8'hEF, 8'h00);
        req_len[3:0] = 4'd3; miso_val = 8'h5A; p0 = pop_cnt;
        exp_txq = '{8'hAB, 8'hCD, 8'hEF};
        exp_rxq = '{{2'b01, 8'h5A}, {2'b01, 8'h5A}, {2'b01, 8'h5A}};
        exp_doneq = '{2'b01}; exp_gntq = '{2'b01};
        req = 2'b01;
        for (int c = 0; c < 20 && gnt == 0; c++) @(negedge CLK);
        req = 2'b00;
        for (int c = 0; c < 400 && got_doneq.size() < 1; c++) @(negedge CLK);
        repeat (3) @(negedge CLK);
        checks++; if (got_txq.size() != exp_txq.size()) begin errors++;
            $display("FAIL single_tx_count: got %0d expected %0d", got_txq.size(), exp_txq.size()); end
        else foreach (exp_txq[k]) begin checks++; if (got_txq[k] !== exp_txq[k]) begin errors++;
            $display("FAIL single_tx[%0d]: got %h expected %h", k, got_txq[k], exp_txq[k]); end end
        checks++; if (got_rxq.size() != exp_rxq.size()) begin errors++;
            $display("FAIL single_rx_count: got %0d expected %0d", got_rxq.size(), exp_rxq.size()); end
        else foreach (exp_rxq[k]) begin checks++; if (got_rxq[k] !== exp_rxq[k]) begin errors++;
            $display("FAIL single_rx[%0d]: got %h expected %h", k, got_rxq[k], exp_rxq[k]); end end
        checks++; if (got_doneq.size() != 1 || got_doneq[0] !== exp_doneq[0]) begin errors++;
            $display("FAIL single_done: got %0d entries expected one %b", got_doneq.size(), exp_doneq[0]); end
        checks++; if (pop_cnt - p0 != 3) begin errors++;
            $display("FAIL single_tx_pop: got %0d expected 3", pop_cnt - p0); end
        checks++; if (got_gntq.size() != 1 || got_gntq[0] !== exp_gntq[0]) begin errors++;
            $display("FAIL single_gnt: got %0d grants expected one %b", got_gntq.size(), exp_gntq[0]); end
    endtask

    task automatic test_rr_order();
        RST_n = 1'b0;
        @(negedge CLK);
        RST_n = 1'b1;
        clear_sb();
        load_src(0, 8'h11, 8'h33, 8'h00, 8'h00);
        load_src(1, 8'h22, 8'h44, 8'h00, 8'h00);
        req_len = {4'd1, 4'd1}; miso_val = 8'h3C;
        exp_txq = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_gntq = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_doneq = '{2'b01, 2'b10, 2'b01, 2'b10};
        req = 2'b11;
        for (int c = 0; c < 800 && got_doneq.size() < 4; c++) @(negedge CLK);
        req = 2'b00;
        repeat (6) @(negedge CLK);
        checks++; if (got_gntq.size() != exp_gntq.size()) begin errors++;
            $display("FAIL rr_gnt_count: got %0d expected %0d", got_gntq.size(), exp_gntq.size()); end
        else foreach (exp_gntq[k]) begin checks++; if (got_gntq[k] !== exp_gntq[k]) begin errors++;
            $display("FAIL rr_gnt[%0d]: got %b expected %b", k, got_gntq[k], exp_gntq[k]); end end
        checks++; if (got_txq.size() != exp_txq.size()) begin errors++;
            $display("FAIL rr_tx_count: got %0d expected %0d", got_txq.size(), exp_txq.size()); end
        else foreach (exp_txq[k]) begin checks++; if (got_txq[k] !== exp_txq[k]) begin errors++;
            $display("FAIL rr_tx[%0d]: got %h expected %h", k, got_txq[k], exp_txq[k]); end end
        checks++; if (got_doneq.size() != exp_doneq.size()) begin errors++;
            $display("FAIL rr_done_count: got %0d expected %0d", got_doneq.size(), exp_doneq.size()); end
        else foreach (exp_doneq[k]) begin checks++; if (got_doneq[k] !== exp_doneq[k]) begin errors++;
            $display("FAIL rr_done[%0d]: got %b expected %b", k, got_doneq[k], exp_doneq[k]); end end
        checks++; if (got_rxq.size() != 4 || got_rxq[1] !== {2'b10, 8'h3C}) begin errors++;
            $display("FAIL rr_rx: got %0d entries expected 4 with second 23c", got_rxq.size()); end
    endtask

    task automatic test_zero_len();
        int gc0, cc0;
        clear_sb();
        req_len = {4'd0, 4'd5};
        exp_doneq = '{2'b10}; exp_gntq = '{2'b10};
        gc0 = gnt_cycles; cc0 = ctl_cycles;
        req = 2'b10;
        for (int c = 0; c < 20 && gnt == 0; c++) @(negedge CLK);
        req = 2'b00;
        repeat (6) @(negedge CLK);
        checks++; if (gnt_cycles - gc0 != 1) begin errors++;
            $display("FAIL zero_gnt_cycles: got %0d expected 1", gnt_cycles - gc0); end
        checks++; if (ctl_cycles - cc0 != 0) begin errors++;
            $display("FAIL zero_spi_ctl: got %0d ctl cycles expected 0", ctl_cycles - cc0); end
        checks++; if (got_doneq.size() != 1 || got_doneq[0] !== exp_doneq[0]) begin errors++;
            $display("FAIL zero_done: got %0d entries expected one %b", got_doneq.size(), exp_doneq[0]); end
        checks++; if (got_gntq.size() != 1 || got_gntq[0] !== exp_gntq[0]) begin errors++;
            $display("FAIL zero_gnt: got %0d grants expected one %b", got_gntq.size(), exp_gntq[0]); end
        checks++; if (got_txq.size() + got_rxq.size() != 0) begin errors++;
            $display("FAIL zero_no_traffic: got %0d items expected 0", got_txq.size() + got_rxq.size()); end
    endtask

    task automatic test_req_drop();
        int p0;
        clear_sb();
        load_src(0, 8'h10, 8'h20, 8'h30, 8'h40);
        req_len = {4'd0, 4'd4}; miso_val = 8'h96; p0 = pop_cnt;
        exp_txq = '{8'h10, 8'h20, 8'h30, 8'h40};
        exp_doneq = '{2'b01};
        req = 2'b01;
        for (int c = 0; c < 40 && pop_cnt == p0; c++) @(negedge CLK);
        req = 2'b00;
        for (int c = 0; c < 400 && got_doneq.size() < 1; c++) @(negedge CLK);
        repeat (3) @(negedge CLK);
        checks++; if (got_txq.size() != exp_txq.size()) begin errors++;
            $display("FAIL drop_tx_count: got %0d expected %0d", got_txq.size(), exp_txq.size()); end
        else foreach (exp_txq[k]) begin checks++; if (got_txq[k] !== exp_txq[k]) begin errors++;
            $display("FAIL drop_tx[%0d]: got %h expected %h", k, got_txq[k], exp_txq[k]); end end
        checks++; if (got_rxq.size() != 4 || got_rxq[3] !== {2'b01, 8'h96}) begin errors++;
            $display("FAIL drop_rx: got %0d entries expected 4 ending 196", got_rxq.size()); end
        checks++; if (got_doneq.size() != 1 || got_doneq[0] !== exp_doneq[0]) begin errors++;
            $display("FAIL drop_done: got %0d entries expected one %b", got_doneq.size(), exp_doneq[0]); end
    endtask

    task automatic test_reset_mid();
        clear_sb();
        load_src(0, 8'h55, 8'h66, 8'h77, 8'h00);
        req_len = {4'd0, 4'd3}; miso_val = 8'hC3;
        req = 2'b01;
        for (int c = 0; c < 20 && gnt == 0; c++) @(negedge CLK);
        req = 2'b00;
        for (int c = 0; c < 200 && !(spi_csn == 1'b0 && spi_ctl == 1'b0); c++) @(negedge CLK);
        #1 RST_n = 1'b0;
        #1;
        checks++; if (spi_ctl !== 1'b0 || gnt !== 2'b00) begin errors++;
            $display("FAIL midreset_async: got ctl=%b gnt=%b expected 0/00", spi_ctl, gnt); end
        checks++; if (spi_txd !== 8'h00) begin errors++;
            $display("FAIL midreset_txd: got %h expected 00", spi_txd); end
        @(negedge CLK);
        RST_n = 1'b1;
        clear_sb();
        load_src(0, 8'h55, 8'h66, 8'h77, 8'h00);
        req_len = {4'd0, 4'd2};
        exp_txq = '{8'h55, 8'h66};
        exp_doneq = '{2'b01};
        req = 2'b01;
        for (int c = 0; c < 20 && gnt == 0; c++) @(negedge CLK);
        req = 2'b00;
        for (int c = 0; c < 400 && got_doneq.size() < 1; c++) @(negedge CLK);
        repeat (3) @(negedge CLK);
        checks++; if (got_txq.size() != exp_txq.size()) begin errors++;
            $display("FAIL clean_tx_count: got %0d expected %0d", got_txq.size(), exp_txq.size()); end
        else foreach (exp_txq[k]) begin checks++; if (got_txq[k] !== exp_txq[k]) begin errors++;
            $display("FAIL clean_tx[%0d]: got %h expected %h", k, got_txq[k], exp_txq[k]); end end
        checks++; if (got_doneq.size() != 1 || got_doneq[0] !== exp_doneq[0]) begin errors++;
            $display("FAIL clean_done: got %0d entries expected one %b", got_doneq.size(), exp_doneq[0]); end
        checks++; if (got_rxq.size() != 2 || got_rxq[1] !== {2'b01, 8'hC3}) begin errors++;
            $display("FAIL clean_rx: got %0d entries expected 2 ending 1c3", got_rxq.size()); end
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        logic [1:0] done_at_err;
        clear_sb();
        hold_high = 1'b1;
        req_len = {4'd0, 4'd2};
        req = 2'b01;
        for (int c = 0; c < 20 && gnt == 0; c++) @(negedge CLK);
        req = 2'b00;
        for (int c = 0; c < 20 && !spi_ctl; c++) @(negedge CLK);
        n = 0;
        while (!err && n < 100) begin
            @(negedge CLK);
            n++;
        end
        done_at_err = done;
        checks++; if (n != TO_CYC - 1) begin errors++;
            $display("FAIL timeout_latency: got %0d expected %0d", n, TO_CYC - 1); end
        checks++; if (done_at_err !== 2'b01) begin errors++;
            $display("FAIL timeout_done: got %b expected 01", done_at_err); end
        @(negedge CLK);
        checks++; if (spi_ctl !== 1'b0 || gnt !== 2'b00) begin errors++;
            $display("FAIL timeout_abort: got ctl=%b gnt=%b expected 0/00", spi_ctl, gnt); end
        hold_high = 1'b0;
        repeat (3) @(negedge CLK);
    endtask
`endif

    initial begin
        for (int i = 0; i < NREQ; i++) for (int j = 0; j < 16; j++) src[i][j] = 8'h00;
        test_reset();
        test_single_burst();
        test_rr_order();
        test_zero_len();
        test_req_drop();
        test_reset_mid();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
